// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode scan driver with per-slot dead time and frame-synchronous value updates.
// Define SEVEN_SEG_BLANK_EN to enable leading-zero blanking of digits 3..1.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_data,
    input  logic        i_load,
    output logic [15:0] o_digit_data,
    output logic [3:0]  o_an,
    output logic        o_pending,
    output logic        o_frame
);
    localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_disp;
    logic [15:0]   r_pend;
    logic          r_pend_v;
    logic [15:0]   r_digit;
    logic [3:0]    r_an;
    logic          r_frame;

    logic          w_slot_end;
    logic          w_wrap;
    logic [3:0]    w_nib;
    logic [3:0]    w_blank;

    assign w_slot_end = (r_cnt == CNT_MAX);
    assign w_wrap     = w_slot_end && (r_idx == 2'd3);
    assign w_nib      = r_disp[{r_idx, 2'b00} +: 4];

    // A digit blanks when it and every more-significant nibble are zero; digit 0 always shows.
    assign w_blank[0] = 1'b0;
    for (genvar k = 1; k < 4; k++) begin : g_blank
`ifdef SEVEN_SEG_BLANK_EN
        assign w_blank[k] = ~|r_disp[15:4*k];
`else
        assign w_blank[k] = 1'b0;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_disp   <= 16'h0000;
            r_pend   <= 16'h0000;
            r_pend_v <= 1'b0;
            r_digit  <= 16'h0000;
            r_an     <= 4'b1111;
            r_frame  <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Outputs follow the pre-edge position so they change only on clock edges.
            r_an    <= (r_cnt < DEAD) ? 4'b1111 : ~(4'b0001 << r_idx);
            r_digit <= w_blank[r_idx] ? 16'h0010 : {12'h000, w_nib};
            r_frame <= w_wrap;

            if (w_wrap) begin
                if (i_load)
                    r_disp <= i_data;
                else if (r_pend_v)
                    r_disp <= r_pend;
                r_pend_v <= 1'b0;
            end else if (i_load) begin
                r_pend   <= i_data;
                r_pend_v <= 1'b1;
            end
        end
    end

    assign o_digit_data = r_digit;
    assign o_an         = r_an;
    assign o_pending    = r_pend_v;
    assign o_frame      = r_frame;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a time-based reference model queues the expected
// outputs for every clock edge, and a monitor compares them after each edge.
module tb_seven_seg_scanner;
    localparam int RD    = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = 4 * RD;
`ifdef SEVEN_SEG_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  an;
        logic [15:0] dd;
        logic        pnd;
        logic        frm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        load;
    logic [15:0] o_digit_data;
    logic [3:0]  o_an;
    logic        o_pending;
    logic        o_frame;

    int checks = 0;
    int fails  = 0;

    exp_t        q[$];
    int          m;          // edges since reset release
    logic [15:0] disp;
    logic [15:0] pend[$];    // loads seen in the current frame

    seven_seg_scanner #(.REFRESH_DIV(RD), .DEAD_CYCLES(DEAD)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_load(load),
        .o_digit_data(o_digit_data), .o_an(o_an), .o_pending(o_pending), .o_frame(o_frame)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] digit_val(input logic [15:0] v, input int idx);
        logic [15:0] hi;
        hi = v >> (4 * idx);
        if (BLANK && idx > 0 && hi == 16'h0) return 16'h0010;
        return {12'h000, hi[3:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m = 0;
        disp = 16'h0;
        pend.delete();
    endtask

    // Expected outputs just after the next edge, advancing the model by one edge.
    task automatic model_edge(input logic r, input logic ld, input logic [15:0] d, output exp_t e);
        int cnt, idx;
        bit wrap;
        if (r) begin
            model_reset();
            e = '{an: 4'hF, dd: 16'h0, pnd: 1'b0, frm: 1'b0};
            return;
        end
        cnt  = m % RD;
        idx  = (m / RD) % 4;
        wrap = (m % FRAME) == FRAME - 1;
        e.an  = (cnt < DEAD) ? 4'hF : (4'hF & ~(4'b0001 << idx));
        e.dd  = digit_val(disp, idx);
        e.frm = wrap;
        if (wrap) begin
            if (ld) disp = d;
            else if (pend.size() != 0) disp = pend[$];
            pend.delete();
        end else if (ld) begin
            pend.push_back(d);
        end
        e.pnd = (pend.size() != 0);
        m++;
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] d);
        exp_t e;
        @(negedge clk);
        rst = r; load = ld; data = d;
        model_edge(r, ld, d, e);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom));
    endtask

    // Advance so that the next step lands on the wrap edge.
    task automatic to_wrap();
        while ((m % FRAME) != FRAME - 1) idle(1);
    endtask

    // Monitor: one expected entry per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("scan_outputs", {12'h0, o_an, o_digit_data, o_pending, o_frame},
                      {12'h0, e.an, e.dd, e.pnd, e.frm});
            end
        end
    end

    initial begin
        rst = 1'b1; load = 1'b0; data = 16'h0;
        model_reset();
        #1;
        check("reset_an",      {28'h0, o_an},         32'hF);
        check("reset_digit",   {16'h0, o_digit_data}, 32'h0);
        check("reset_pending", {31'h0, o_pending},    32'h0);
        check("reset_frame",   {31'h0, o_frame},      32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0);

        // Release, idle a frame, then a mid-frame load.
        idle(FRAME + 5);
        step(1'b0, 1'b1, 16'h12AB);
        idle(2 * FRAME);

        // Two loads in one frame: last wins.
        step(1'b0, 1'b1, 16'h1111);
        idle(3);
        step(1'b0, 1'b1, 16'h2222);
        idle(2 * FRAME);

        // Load on the wrap edge bypasses the pending register, and beats an older pending value.
        to_wrap();
        step(1'b0, 1'b1, 16'h00C3);
        idle(FRAME);
        step(1'b0, 1'b1, 16'hBEEF);
        to_wrap();
        step(1'b0, 1'b1, 16'h00C3);
        idle(FRAME);

        // Blanking patterns.
        step(1'b0, 1'b1, 16'h0050);
        idle(2 * FRAME);
        step(1'b0, 1'b1, 16'h0000);
        idle(2 * FRAME);
        step(1'b0, 1'b1, 16'h0700);
        idle(2 * FRAME);

        // Randomized loads, biased towards the wrap edge now and then.
        for (int i = 0; i < 900; i++) begin
            logic ld;
            ld = ($urandom_range(0, 19) == 0) ||
                 (((m % FRAME) == FRAME - 1) && ($urandom_range(0, 2) == 0));
            step(1'b0, ld, 16'($urandom));
        end

        // Async reset while digit 2 is lit with a load pending.
        step(1'b0, 1'b1, 16'h4321);
        idle(FRAME);
        while (!(((m / RD) % 4) == 2 && (m % RD) >= DEAD + 1)) idle(1);
        step(1'b0, 1'b1, 16'h9876);
        @(posedge clk);
        #3;
        check("pre_reset_an",      {28'h0, o_an},      32'hB);
        check("pre_reset_pending", {31'h0, o_pending}, 32'h1);
        rst = 1'b1;
        model_reset();
        #1;
        check("async_reset_an",      {28'h0, o_an},      32'hF);
        check("async_reset_pending", {31'h0, o_pending}, 32'h0);
        check("async_reset_digit",   {16'h0, o_digit_data}, 32'h0);
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        idle(2 * FRAME + 3);

        @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
